de_scoreboard: RTL

DE_SCOREBOARD -- requirements
Module: de_scoreboard

---
 rtl/de_scoreboard.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/de_scoreboard.sv
// Decode-stage register scoreboard: an in-order queue of in-flight destination IDs,
// per-register pending counts, and a tail-squash FSM. Optional macro: DE_SB_WB_BYPASS_EN.
module de_scoreboard #(
    parameter int NREGS   = 32,
    parameter int REGBITS = 5,
    parameter int DEPTH   = 4,
    parameter int CNTW    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               issue_valid,
    input  logic               issue_wr,
    input  logic [REGBITS-1:0] issue_rd,
    input  logic               rs1_rd_en,
    input  logic               rs2_rd_en,
    input  logic [REGBITS-1:0] rs1,
    input  logic [REGBITS-1:0] rs2,
    input  logic               wb_valid,
    input  logic [REGBITS-1:0] wb_rd,
    input  logic               flush_valid,
    input  logic [CNTW-1:0]    flush_cnt,
    output logic               stall,
    output logic               full,
    output logic               empty,
    output logic [CNTW-1:0]    inflight_cnt,
    output logic               flushing,
    output logic               err
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    state_t             state_r;
    logic [REGBITS-1:0] q_r [DEPTH];
    logic [CNTW-1:0]    pend_r [NREGS];
    logic [PW-1:0]      head_r;
    logic [PW-1:0]      tail_r;
    logic [CNTW-1:0]    count_r;
    logic [CNTW-1:0]    remaining_r;
    logic               err_r;

    logic [PW-1:0]      tail_last_s;
    logic [REGBITS-1:0] head_id_s;
    logic [REGBITS-1:0] tail_id_s;
    logic               haz1_s;
    logic               haz2_s;
    logic               byp1_s;
    logic               byp2_s;
    logic               wr_nz_s;
    logic               push_s;
    logic               flush_pop_s;
    logic               wb_pop_s;
    logic               wb_err_s;
    logic               flush_start_s;
    logic               clamp_s;
    logic [CNTW-1:0]    count_next_s;

    // Hazard detection, stall and the push/pop decisions for this cycle
    always_comb begin
        tail_last_s   = tail_r - PW'(1);
        head_id_s     = q_r[head_r];
        tail_id_s     = q_r[tail_last_s];
        empty         = (count_r == CNTW'(0));
        full          = (count_r == CNTW'(DEPTH));
        inflight_cnt  = count_r;
        flushing      = (state_r == FLUSH);
        err           = err_r;
`ifdef DE_SB_WB_BYPASS_EN
        // The writeback stage writes the register file before decode reads it.
        byp1_s = wb_valid & ~empty & (head_id_s == rs1) & (wb_rd == rs1) & (pend_r[rs1] == CNTW'(1));
        byp2_s = wb_valid & ~empty & (head_id_s == rs2) & (wb_rd == rs2) & (pend_r[rs2] == CNTW'(1));
`else
        byp1_s = 1'b0;
        byp2_s = 1'b0;
`endif
        haz1_s        = rs1_rd_en & (rs1 != REGBITS'(0)) & (pend_r[rs1] != CNTW'(0)) & ~byp1_s;
        haz2_s        = rs2_rd_en & (rs2 != REGBITS'(0)) & (pend_r[rs2] != CNTW'(0)) & ~byp2_s;
        wr_nz_s       = issue_wr & (issue_rd != REGBITS'(0));
        stall         = issue_valid & (flushing | (full & wr_nz_s) | haz1_s | haz2_s);
        push_s        = issue_valid & ~stall & wr_nz_s;
        flush_pop_s   = flushing & ~empty;
        // With one entry left, a same-cycle writeback and tail squash remove it only once.
        wb_pop_s      = wb_valid & ~empty & ~(flush_pop_s & (count_r == CNTW'(1)));
        wb_err_s      = wb_valid & (empty | (wb_rd != head_id_s));
        flush_start_s = ~flushing & flush_valid & (flush_cnt != CNTW'(0)) & ~empty;
        clamp_s       = flush_start_s & (flush_cnt > count_r);
        count_next_s  = count_r + CNTW'(push_s) - CNTW'(wb_pop_s) - CNTW'(flush_pop_s);
    end

    // Queue, pending counters, error flag and flush FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            head_r      <= PW'(0);
            tail_r      <= PW'(0);
            count_r     <= CNTW'(0);
            remaining_r <= CNTW'(0);
            err_r       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_r[i] <= REGBITS'(0);
            end
            for (int i = 0; i < NREGS; i++) begin
                pend_r[i] <= CNTW'(0);
            end
        end else begin
            if (push_s) begin
                q_r[tail_r] <= issue_rd;
            end
            head_r  <= head_r + PW'(wb_pop_s);
            tail_r  <= tail_r + PW'(push_s) - PW'(flush_pop_s);
            count_r <= count_next_s;
            err_r   <= err_r | wb_err_s | clamp_s;
            for (int i = 0; i < NREGS; i++) begin
                pend_r[i] <= pend_r[i]
                           + CNTW'(push_s      && (issue_rd  == REGBITS'(i)))
                           - CNTW'(wb_pop_s    && (head_id_s == REGBITS'(i)))
                           - CNTW'(flush_pop_s && (tail_id_s == REGBITS'(i)));
            end
            case (state_r)
                IDLE: begin
                    if (flush_start_s) begin
                        state_r     <= FLUSH;
                        remaining_r <= clamp_s ? count_r : flush_cnt;
                    end else begin
                        state_r     <= IDLE;
                        remaining_r <= CNTW'(0);
                    end
                end
                FLUSH: begin
                    if (!flush_pop_s || remaining_r <= CNTW'(1) || count_next_s == CNTW'(0)) begin
                        state_r     <= IDLE;
                        remaining_r <= CNTW'(0);
                    end else begin
                        state_r     <= FLUSH;
                        remaining_r <= remaining_r - CNTW'(1);
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    remaining_r <= CNTW'(0);
                end
            endcase
        end
    end
endmodule
